// File: rtl/stepper_pulse_gen_if.sv
// Command/status bundle between the block-movement controller (master) and one
// stepper pulse generator (slave).
interface stepper_pulse_gen_if #(
    parameter int STEP_W = 16
);
    logic              i_start;
    logic [STEP_W-1:0] i_steps;
    logic              i_dir;
    logic              i_abort;
    logic              o_step;
    logic              o_direction;
    logic              o_busy;
    logic              o_done;
    logic [STEP_W-1:0] o_remaining;

    modport master (
        output i_start, i_steps, i_dir, i_abort,
        input  o_step, o_direction, o_busy, o_done, o_remaining
    );

    modport slave (
        input  i_start, i_steps, i_dir, i_abort,
        output o_step, o_direction, o_busy, o_done, o_remaining
    );
endinterface

// File: rtl/stepper_pulse_gen.sv
// Single-axis stepper pulse generator: direction setup, fixed-rate step pulses,
// abort at the end of a LOW phase, one-cycle done pulse.
module stepper_pulse_gen #(
    parameter int STEP_W      = 16,
    parameter int HALF_PERIOD = 25000,
    parameter int SETUP_CYC   = 50
) (
    input  logic                i_Clk,
    input  logic                i_rst_n,
    stepper_pulse_gen_if.slave  bus
);
    localparam int MAX_CYC = (HALF_PERIOD > SETUP_CYC) ? HALF_PERIOD : SETUP_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]  HALF_LOAD  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0]  SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [STEP_W-1:0] ONE_STEP   = STEP_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;

    // NOTE: every register here uses non-blocking assignments so all state and
    // outputs update together on the edge, with no ordering dependence.
    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            phase_cnt       <= '0;
            bus.o_step      <= 1'b0;
            bus.o_direction <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
            bus.o_remaining <= '0;
        end else begin
            bus.o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        bus.o_direction <= bus.i_dir;
                        bus.o_remaining <= bus.i_steps;
                        bus.o_busy      <= 1'b1;
                        phase_cnt       <= SETUP_LOAD;
                        state           <= SETUP;
                    end
                end

                // A zero-step command leaves through here after one busy cycle.
                SETUP: begin
                    if (bus.i_abort || bus.o_remaining == '0) begin
                        bus.o_busy <= 1'b0;
                        bus.o_done <= 1'b1;
                        phase_cnt  <= '0;
                        state      <= DONE;
                    end else if (phase_cnt == '0) begin
                        bus.o_step <= 1'b1;
                        phase_cnt  <= HALF_LOAD;
                        state      <= HIGH;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end

                HIGH: begin
                    if (phase_cnt == '0) begin
                        bus.o_step <= 1'b0;
                        phase_cnt  <= HALF_LOAD;
                        state      <= LOW;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end

                // Abort is only honoured once the full LOW time has elapsed.
                LOW: begin
                    if (phase_cnt == '0) begin
                        if (bus.o_remaining != '0) begin
                            bus.o_remaining <= bus.o_remaining - ONE_STEP;
                        end
                        if (bus.o_remaining <= ONE_STEP || bus.i_abort) begin
                            bus.o_busy <= 1'b0;
                            bus.o_done <= 1'b1;
                            phase_cnt  <= '0;
                            state      <= DONE;
                        end else begin
                            bus.o_step <= 1'b1;
                            phase_cnt  <= HALF_LOAD;
                            state      <= HIGH;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    bus.o_step <= 1'b0;
                    bus.o_busy <= 1'b0;
                    phase_cnt  <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Directed bench for stepper_pulse_gen with HALF_PERIOD=4, SETUP_CYC=2: a table of
// back-to-back moves plus hand-written reset and max-count sequences.
module tb_stepper_pulse_gen;
    localparam int STEP_W = 16;
    localparam int HP     = 4;
    localparam int SC     = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    stepper_pulse_gen_if #(.STEP_W(STEP_W)) bus ();

    stepper_pulse_gen #(
        .STEP_W      (STEP_W),
        .HALF_PERIOD (HP),
        .SETUP_CYC   (SC)
    ) dut (
        .i_Clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // t counts sampled cycles after the start strobe; t=1 is the first busy cycle.
    typedef struct {
        int steps;
        bit dir;
        int abort_t;      // -1 none, 0 together with start, else cycle index
        int restart_t;    // 0 none, else cycle index of an ignored re-start
        int exp_first;    // first cycle with o_step high, -1 if no pulse
        int exp_pulses;
        int exp_done_t;
        int exp_rem;
        int exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives the command at the current negedge and returns at the negedge of the
    // idle cycle following o_done, so a following call starts back-to-back.
    task automatic run_move(input string tag, input vec_t v);
        int t, first_rise, pulses, done_t, busy_cyc, bad_shape, bad_dir, high_run, low_run;
        logic prev_step;
        logic [STEP_W-1:0] rem_at_done;
        bus.i_start = 1'b1;
        bus.i_steps = STEP_W'(v.steps);
        bus.i_dir   = v.dir;
        bus.i_abort = (v.abort_t == 0);
        t = 0; first_rise = -1; pulses = 0; done_t = -1; busy_cyc = 0;
        bad_shape = 0; bad_dir = 0; high_run = 0; low_run = 0;
        prev_step = 1'b0; rem_at_done = '0;
        while (done_t < 0 && t < 400) begin
            @(negedge clk);
            t++;
            if (t == 1 || (v.restart_t > 0 && t == v.restart_t + 1)) bus.i_start = 1'b0;
            if (v.restart_t > 0 && t == v.restart_t) begin
                bus.i_start = 1'b1;
                bus.i_steps = 16'd7;
                bus.i_dir   = ~v.dir;
            end
            if (v.abort_t > 0 && t == v.abort_t) bus.i_abort = 1'b1;
            if (bus.o_busy) begin
                busy_cyc++;
                if (bus.o_direction !== v.dir) bad_dir++;
            end
            if (bus.o_step) begin
                if (!prev_step) begin
                    pulses++;
                    if (first_rise < 0) first_rise = t;
                    else if (low_run != HP) bad_shape++;
                    if (int'(bus.o_remaining) != v.steps - pulses + 1) bad_shape++;
                    high_run = 1;
                end else begin
                    high_run++;
                end
            end else begin
                if (prev_step) begin
                    if (high_run != HP) bad_shape++;
                    low_run = 1;
                end else begin
                    low_run++;
                end
            end
            prev_step = bus.o_step;
            if (bus.o_done) begin
                done_t      = t;
                rem_at_done = bus.o_remaining;
            end
        end
        bus.i_abort = 1'b0;
        @(negedge clk);
        check({tag, " idle_after_done"}, {29'd0, bus.o_done, bus.o_busy, bus.o_step}, 32'd0);
        check({tag, " done_cycle"}, done_t, v.exp_done_t);
        check({tag, " first_rise"}, first_rise, v.exp_first);
        check({tag, " pulses"}, pulses, v.exp_pulses);
        check({tag, " rem_at_done"}, {16'd0, rem_at_done}, v.exp_rem);
        check({tag, " busy_cycles"}, busy_cyc, v.exp_busy);
        check({tag, " pulse_shape_errors"}, bad_shape, 0);
        check({tag, " dir_errors"}, bad_dir, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t vecs[6];
        vec_t post;
        int zero_done;
        vecs[0] = '{steps:3,  dir:1'b1, abort_t:-1, restart_t:0, exp_first:3,  exp_pulses:3, exp_done_t:27, exp_rem:0, exp_busy:26};
        vecs[1] = '{steps:1,  dir:1'b0, abort_t:-1, restart_t:0, exp_first:3,  exp_pulses:1, exp_done_t:11, exp_rem:0, exp_busy:10};
        vecs[2] = '{steps:0,  dir:1'b0, abort_t:-1, restart_t:0, exp_first:-1, exp_pulses:0, exp_done_t:2,  exp_rem:0, exp_busy:1};
        vecs[3] = '{steps:10, dir:1'b1, abort_t:12, restart_t:0, exp_first:3,  exp_pulses:2, exp_done_t:19, exp_rem:8, exp_busy:18};
        vecs[4] = '{steps:2,  dir:1'b1, abort_t:0,  restart_t:0, exp_first:-1, exp_pulses:0, exp_done_t:2,  exp_rem:2, exp_busy:1};
        vecs[5] = '{steps:2,  dir:1'b1, abort_t:-1, restart_t:5, exp_first:3,  exp_pulses:2, exp_done_t:19, exp_rem:0, exp_busy:18};
        post    = '{steps:2,  dir:1'b1, abort_t:-1, restart_t:0, exp_first:3,  exp_pulses:2, exp_done_t:19, exp_rem:0, exp_busy:18};

        bus.i_start = 1'b0;
        bus.i_steps = '0;
        bus.i_dir   = 1'b0;
        bus.i_abort = 1'b0;

        // Reset state, both during and just after reset.
        #1;
        check("reset_outputs", {28'd0, bus.o_step, bus.o_direction, bus.o_busy, bus.o_done}, 32'd0);
        check("reset_remaining", {16'd0, bus.o_remaining}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", {28'd0, bus.o_step, bus.o_direction, bus.o_busy, bus.o_done}, 32'd0);

        // Back-to-back table: vecs[1] starts in the idle cycle after vecs[0]'s done.
        for (int i = 0; i < 6; i++) begin
            run_move($sformatf("vec%0d", i), vecs[i]);
        end

        // Max-count command, then asynchronous reset in the middle of the first LOW phase.
        bus.i_start = 1'b1;
        bus.i_steps = 16'hFFFF;
        bus.i_dir   = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("max_steps_latched", {16'd0, bus.o_remaining}, 32'h0000_FFFF);
        check("max_dir_latched", {31'd0, bus.o_direction}, 32'd1);
        repeat (6) @(negedge clk);
        check("max_in_low", {30'd0, bus.o_busy, bus.o_step}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {28'd0, bus.o_step, bus.o_direction, bus.o_busy, bus.o_done}, 32'd0);
        check("async_reset_remaining", {16'd0, bus.o_remaining}, 32'd0);
        zero_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_done) zero_done++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.o_done) zero_done++;
        end
        check("no_done_after_reset", zero_done, 0);
        run_move("post_reset", post);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
